// File: rtl/mul_issue_ctrl.sv
// Issue/retire sequencer for a fixed-latency pipelined 32x32 multiplier
// serving RV32M MUL/MULH/MULHSU/MULHU. Issue is credit-throttled so that
// every op leaving the multiplier pipeline always finds a free output slot.
module mul_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W       = 5,
  parameter int OUT_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [XLEN-1:0]   req_rs1_i,
  input  logic [XLEN-1:0]   req_rs2_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              mul_start_o,
  output logic              mul_signed_o,
  output logic [XLEN-1:0]   mul_x_o,
  output logic [XLEN-1:0]   mul_y_o,
  input  logic [2*XLEN-1:0] mul_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              busy_o
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // The multiplier runs MULHSU unsigned; subtracting rs2 when rs1 is negative
  // turns the unsigned high word into the signed-by-unsigned high word.
  function automatic logic [XLEN-1:0] sel_result(
    input logic [1:0]        op,
    input logic [2*XLEN-1:0] prod,
    input logic              rs1_neg,
    input logic [XLEN-1:0]   rs2
  );
    logic [XLEN-1:0] hi;
    hi = prod[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:           sel_result = prod[XLEN-1:0];
      OP_MULHSU:        sel_result = hi - (rs1_neg ? rs2 : '0);
      OP_MULH, OP_MULHU: sel_result = hi;
      default:          sel_result = hi;
    endcase
  endfunction

  // Issue stage
  logic              iss_vld_q, iss_vld_d;
  logic [1:0]        iss_op_q, iss_op_d;
  logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
  logic [XLEN-1:0]   mul_x_q, mul_x_d;
  logic [XLEN-1:0]   mul_y_q, mul_y_d;
  logic              mul_signed_q, mul_signed_d;

  // Tracking slots, slot[MUL_LATENCY-1] lines up with the product
  logic [MUL_LATENCY-1:0] slot_vld_q, slot_vld_d;
  logic [MUL_LATENCY-1:0] slot_neg_q, slot_neg_d;
  logic [1:0]             slot_op_q  [MUL_LATENCY];
  logic [1:0]             slot_op_d  [MUL_LATENCY];
  logic [TAG_W-1:0]       slot_tag_q [MUL_LATENCY];
  logic [TAG_W-1:0]       slot_tag_d [MUL_LATENCY];
  logic [XLEN-1:0]        slot_rs2_q [MUL_LATENCY];
  logic [XLEN-1:0]        slot_rs2_d [MUL_LATENCY];

  // Output FIFO and credit counters
  logic [XLEN-1:0]   fifo_data_q [OUT_DEPTH];
  logic [TAG_W-1:0]  fifo_tag_q  [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  logic              accept;
  logic              ret_vld;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   ret_data;
  logic [CNT_W:0]    credit_used;

  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign req_ready_o = !rst && !flush_i && (credit_used < (CNT_W+1)'(OUT_DEPTH));
  assign accept      = req_valid_i && req_ready_o;

  assign ret_vld  = slot_vld_q[MUL_LATENCY-1];
  assign ret_data = sel_result(slot_op_q[MUL_LATENCY-1], mul_result_i,
                               slot_neg_q[MUL_LATENCY-1], slot_rs2_q[MUL_LATENCY-1]);
  assign push     = ret_vld && !flush_i;
  assign pop      = rsp_valid_o && rsp_ready_i;

  assign mul_start_o  = iss_vld_q;
  assign mul_signed_o = mul_signed_q;
  assign mul_x_o      = mul_x_q;
  assign mul_y_o      = mul_y_q;
  assign rsp_valid_o  = (fifo_cnt_q != '0);
  assign rsp_data_o   = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_tag_o    = rsp_valid_o ? fifo_tag_q[rd_ptr_q] : '0;
  assign busy_o       = (inflight_q != '0) || (fifo_cnt_q != '0);

  // Capture accepted request; operands hold between issues
  always_comb begin
    iss_vld_d    = accept;
    iss_op_d     = iss_op_q;
    iss_tag_d    = iss_tag_q;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    mul_signed_d = mul_signed_q;
    if (accept) begin
      iss_op_d     = req_op_i;
      iss_tag_d    = req_tag_i;
      mul_x_d      = req_rs1_i;
      mul_y_d      = req_rs2_i;
      mul_signed_d = (req_op_i == OP_MULH);
    end
  end

  // Advance the tracking slots one step per cycle, flush kills them all
  always_comb begin
    slot_vld_d[0] = iss_vld_q;
    slot_neg_d[0] = mul_x_q[XLEN-1];
    slot_op_d[0]  = iss_op_q;
    slot_tag_d[0] = iss_tag_q;
    slot_rs2_d[0] = mul_y_q;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      slot_vld_d[i] = slot_vld_q[i-1];
      slot_neg_d[i] = slot_neg_q[i-1];
      slot_op_d[i]  = slot_op_q[i-1];
      slot_tag_d[i] = slot_tag_q[i-1];
      slot_rs2_d[i] = slot_rs2_q[i-1];
    end
    if (flush_i) begin
      slot_vld_d = '0;
    end
  end

  // FIFO pointers and both credit counters
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(ret_vld);
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      inflight_d = '0;
    end
  end

  // Control state and multiplier-facing outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_q    <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      mul_signed_q <= 1'b0;
      slot_vld_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      inflight_q   <= '0;
    end else begin
      iss_vld_q    <= iss_vld_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      mul_signed_q <= mul_signed_d;
      slot_vld_q   <= slot_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      inflight_q   <= inflight_d;
    end
  end

  // Payload registers, qualified by the valid bits above
  always_ff @(posedge clk) begin
    iss_op_q   <= iss_op_d;
    iss_tag_q  <= iss_tag_d;
    slot_neg_q <= slot_neg_d;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      slot_op_q[i]  <= slot_op_d[i];
      slot_tag_q[i] <= slot_tag_d[i];
      slot_rs2_q[i] <= slot_rs2_d[i];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ret_data;
      fifo_tag_q[wr_ptr_q]  <= slot_tag_q[MUL_LATENCY-1];
    end
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequences the fixed-latency pipelined 32x32 integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Accepts requests from the execute stage through a valid/ready handshake and drives the multiplier start, sign-mode and operands.
- Tracks in-flight operations, selects and corrects the result word, and returns tagged results through a credit-protected output FIFO.
- The multiplier pipeline cannot stall, so issue is throttled by credits. Flush discards all work.

Parameters:
XLEN, 32, operand width
MUL_LATENCY, 4, cycles from mul_start_o high to mul_result_i valid (posedge-sampled)
TAG_W, 5, request tag width
OUT_DEPTH, 4, output FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all in-flight and buffered ops
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_rs1_i  in  XLEN  operand A
req_rs2_i  in  XLEN  operand B
req_tag_i  in  TAG_W  destination tag
mul_start_o  out  1  one-cycle start pulse to multiplier
mul_signed_o  out  1  multiplier signed mode
mul_x_o  out  XLEN  multiplier X
mul_y_o  out  XLEN  multiplier Y
mul_result_i  in  2*XLEN  multiplier product
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  XLEN  result word
rsp_tag_o  out  TAG_W  tag of result
busy_o  out  1  any op in flight or buffered

Behaviour:
- Reset: all outputs 0, including req_ready_o, rsp_valid_o and busy_o. In-flight valid bits, FIFO pointers and count are cleared. req_ready_o may rise the first cycle after rst deasserts. Reset mid-operation drops everything, and later mul_result_i values are ignored.
- Credits: `req_ready_o = !rst && !flush_i && (fifo_count + inflight_count < OUT_DEPTH)`. This is combinational from registered counts. It guarantees every retiring op has a FIFO slot.
- Issue: on accept in cycle A, register the operands, and in cycle A+1 drive:
  - mul_start_o=1 for exactly one cycle;
  - mul_x_o=rs1, mul_y_o=rs2;
  - mul_signed_o=1 only for MULH.
  - MULHSU and MULHU issue unsigned.
  - Outside issue cycles, mul_start_o=0 and the operand outputs hold their last value.
- Tracking: a MUL_LATENCY-deep shift register of slots, advancing every cycle. Each slot holds valid, op, tag, rs1[XLEN-1] and rs2. Back-to-back accepts are allowed every cycle.
- Retire: in cycle A+1+MUL_LATENCY, if the slot is valid, compute the result and push it to the FIFO at the end of that cycle:
  - MUL: product[XLEN-1:0].
  - MULH, MULHU: product[2XLEN-1:XLEN].
  - MULHSU: product[2XLEN-1:XLEN] minus (rs1 sign ? rs2 : 0), mod 2^XLEN.
- Latency: rsp_valid_o is first high in cycle A+2+MUL_LATENCY (A+6 at default) with an empty FIFO and rsp_ready_i=1. Responses leave strictly in accept order.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - rsp_* driven from the head.
  - Simultaneous push and pop keeps the count.
  - Push when full cannot occur (credit invariant); the verifier asserts it.
  - Pop when empty is ignored.
  - rsp_data_o and rsp_tag_o are stable while rsp_valid_o=1 and rsp_ready_i=0.
- inflight_count: +1 on accept, -1 when a valid slot retires; both in the same cycle leaves it unchanged.
- Flush (sampled at a posedge):
  - Clears all slot valid bits, FIFO count and pointers.
  - rsp_valid_o=0 and inflight_count=0 from the next cycle.
  - No request is accepted in the flush cycle.
  - A start pulse already scheduled for the next cycle is suppressed.
  - Stale products emerging later are ignored.
- `busy_o = (inflight_count != 0) || (fifo_count != 0)`.

Test Plan:
1. MUL rs1=7, rs2=6, tag=3, accept at cycle 10 -> mul_start_o=1, mul_signed_o=0 at cycle 11; rsp_valid_o at 16, data=42, tag=3.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000, with mul_signed_o=1.
3. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=5, rs2=0x80000000 -> 0x00000002.
4. rsp_ready_i=0 with req_valid_i held high -> exactly 4 accepts in consecutive cycles, then req_ready_o=0. Raise rsp_ready_i -> 4 responses in tag order, then req_ready_o reasserts and busy_o drops once empty.
5. 3 ops accepted back-to-back, flush_i pulsed 2 cycles after the last accept -> no rsp_valid_o ever, busy_o=0 the next cycle, req_ready_o=1. A new MUL 3x3 returns 9 after its normal latency.
6. rst asserted while 2 ops are in flight -> all outputs 0 the next cycle and no responses appear later. After release, MULHU 0x10000 x 0x10000 -> 0x00000001.
